interval_violation_monitor: RTL and testbench
=============================================

// Module: interval_violation_monitor
// PURPOSE
//  Multi-channel event-interval checker. Measures clock cycles between successive event pulses per channel.
//  Flags intervals shorter than min_gap (early) or longer than max_gap (late).
//  Successor to the single-channel fixed-period predict-time check; sits beside counters and datapaths under test.
//  Feeds sticky status and an interrupt to the host.
// PARAMETERS
//  NUM_CH   4    number of independent event channels
//  CNT_W    8    gap counter / threshold width; counter saturates at 2^CNT_W-1
//  TS_W     16   timestamp width (used only with IVM_VIOL_TS_EN)
// PORTS
//  clk          in   1            single clock, all logic on posedge
//  rst          in   1            synchronous, active-high reset
//  en           in   1            global enable
//  event_in     in   NUM_CH       per-channel event strobe, one cycle = one event
//  min_gap      in   CNT_W        minimum legal gap, shared by all channels
//  max_gap      in   CNT_W        maximum legal gap; 0 disables the late check
//  clr_status   in   NUM_CH       write-1-to-clear for viol_status bits
//  irq_en       in   NUM_CH       interrupt mask per channel
//  early_pulse  out  NUM_CH       1-cycle pulse, early violation
//  late_pulse   out  NUM_CH       1-cycle pulse, late violation
//  viol_status  out  NUM_CH       sticky violation flag per channel
//  last_gap     out  NUM_CH*CNT_W last measured gap; ch i at [i*CNT_W +: CNT_W]
//  irq          out  1            |(viol_status & irq_en), registered
//  first_viol_ts out TS_W         timestamp of first violation (see CONFIGURATION)
//  first_viol_ch out NUM_CH       one-hot channel(s) of first violation
// BEHAVIOUR
//  - Reset: all outputs 0; every channel IDLE; gap counters 0; timestamp counter 0.
//  - Per-channel FSM: IDLE -> ARMED on first event; ARMED -> LATE on late detect; LATE -> ARMED on event.
//  - Gap counter g (ARMED/LATE only):
//    - Event in cycle t loads g=1 at t+1.
//    - Each non-event cycle increments g, saturating at all-ones.
//    - Consecutive-cycle events therefore measure gap 1.
//  - Event in ARMED:
//    - last_gap <= g.
//    - If g < min_gap, early_pulse is high in the next cycle and the status bit is set.
//  - Event in LATE:
//    - last_gap <= g; no early check.
//    - Returns to ARMED with g restarted.
//  - Event in IDLE: enters ARMED; no measurement; last_gap unchanged.
//  - Late check, in ARMED, with max_gap != 0:
//    - Triggers when g == max_gap and there is no event this cycle.
//    - late_pulse is high in the next cycle; the status bit is set; FSM goes to LATE.
//    - Fires at most once per interval.
//  - Thresholds are sampled live each cycle. min_gap=0 never gives an early violation.
//  - All pulses and status outputs are registered: 1-cycle latency from the detecting cycle.
//  - viol_status: set has priority over a same-cycle clr_status on the same bit.
//  - irq: follows viol_status & irq_en with 1 further cycle of latency.
//  - en=0: all channels forced IDLE; g=0; no pulses; viol_status, last_gap and irq retained.
//  - Re-enabling (en=1) requires a fresh first event per channel.
//  - rst mid-interval: discards measurement; no pulses in the following cycle.
// CONFIGURATION
//  - IVM_VIOL_TS_EN defined:
//    - Free-running TS_W timestamp counter, runs while en=1 and wraps at 2^TS_W.
//    - Trigger: viol_status goes from all-zero to non-zero.
//    - On trigger: first_viol_ts <= timestamp of the detecting cycle; first_viol_ch <= channels detecting that cycle.
//    - Held until viol_status returns to all-zero.
//  - IVM_VIOL_TS_EN undefined: no timestamp logic; first_viol_ts and first_viol_ch tied to 0.
// TESTING (NUM_CH=4, CNT_W=8, min_gap=10, max_gap=12, en=1)
//  - Regular: ch0 events every 10 cycles x5 -> no pulses; last_gap[0]=10; viol_status=0.
//  - Early: ch1 events at gap 10 then 7 -> early_pulse[1] 1 cycle after the 2nd event; last_gap[1]=7;
//    viol_status[1]=1; irq=1 with irq_en[1]=1.
//  - Late: ch2 event, then silence -> late_pulse[2] exactly once, 1 cycle after g=12; next event at gap 20 gives
//    last_gap=20 and no early pulse.
//  - Clear race: clr_status[1] in the same cycle as a new ch1 violation -> viol_status[1] stays 1;
//    a later lone clear -> 0.
//  - Disable/reset: en=0 mid-interval, en=1, event at gap 3 -> no early pulse (first event re-arms);
//    rst mid-run -> all outputs 0 next cycle.
//  - IVM_VIOL_TS_EN: violations on ch3 at ts=40, then ch0 at ts=55 -> first_viol_ts=40, first_viol_ch=4'b1000;
//    clear all -> both return to 0.

Source files
------------

// File: rtl/interval_violation_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : interval_violation_monitor_if
//  Purpose  : Bundles the host-facing control and status signals of the
//             multi-channel event-interval monitor.
//  Ports    : en, event_in, min_gap, max_gap, clr_status, irq_en  (to monitor)
//             early_pulse, late_pulse, viol_status, last_gap, irq,
//             first_viol_ts, first_viol_ch                      (from monitor)
//  Modports : master (stimulus / host side), slave (monitor side)
//  Revision : 1.0  initial release
// ============================================================================
interface interval_violation_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int TS_W   = 16
);
  logic                    en;
  logic [NUM_CH-1:0]       event_in;
  logic [CNT_W-1:0]        min_gap;
  logic [CNT_W-1:0]        max_gap;
  logic [NUM_CH-1:0]       clr_status;
  logic [NUM_CH-1:0]       irq_en;
  logic [NUM_CH-1:0]       early_pulse;
  logic [NUM_CH-1:0]       late_pulse;
  logic [NUM_CH-1:0]       viol_status;
  logic [NUM_CH*CNT_W-1:0] last_gap;
  logic                    irq;
  logic [TS_W-1:0]         first_viol_ts;
  logic [NUM_CH-1:0]       first_viol_ch;

  modport master (
    output en, event_in, min_gap, max_gap, clr_status, irq_en,
    input  early_pulse, late_pulse, viol_status, last_gap, irq,
           first_viol_ts, first_viol_ch
  );

  modport slave (
    input  en, event_in, min_gap, max_gap, clr_status, irq_en,
    output early_pulse, late_pulse, viol_status, last_gap, irq,
           first_viol_ts, first_viol_ch
  );
endinterface
`default_nettype wire

// File: rtl/interval_violation_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : interval_violation_monitor
//  Purpose  : Per-channel event-interval checker. Counts cycles between
//             successive event strobes and flags intervals shorter than
//             min_gap (early) or reaching max_gap without an event (late).
//             Sticky status, masked interrupt and optional first-violation
//             timestamp capture.
//  Ports    : clk  - clock, all logic on posedge
//             rst  - synchronous active-high reset
//             bus  - interval_violation_monitor_if.slave (control/status)
//  Options  : IVM_VIOL_TS_EN - when defined, adds a free-running timestamp
//             and first-violation capture; otherwise first_viol_ts and
//             first_viol_ch are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module interval_violation_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int TS_W   = 16
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  interval_violation_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_LATE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] G_MAX = '1;
  localparam logic [CNT_W-1:0] G_ONE = CNT_W'(1);

  logic [NUM_CH-1:0]       early_det;
  logic [NUM_CH-1:0]       late_det;
  logic [NUM_CH-1:0]       early_q;
  logic [NUM_CH-1:0]       late_q;
  logic [NUM_CH-1:0]       status_q;
  logic [NUM_CH-1:0]       status_next;
  logic                    irq_q;
  logic [NUM_CH*CNT_W-1:0] last_gap_w;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t           state;
      logic [CNT_W-1:0] gap;
      logic [CNT_W-1:0] last_gap_q;
      logic             ev;

      assign ev = bus.event_in[i];

      // Detection is combinational on the current count so the registered
      // pulse appears exactly one cycle after the detecting cycle.
      assign early_det[i] = bus.en && (state == S_ARMED) && ev && (gap < bus.min_gap);
      assign late_det[i]  = bus.en && (state == S_ARMED) && !ev &&
                            (bus.max_gap != '0) && (gap == bus.max_gap);

      assign last_gap_w[i*CNT_W +: CNT_W] = last_gap_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          state      <= S_IDLE;
          gap        <= '0;
          last_gap_q <= '0;
        end else if (!bus.en) begin
          // Disabling abandons the current interval; last_gap is kept.
          state <= S_IDLE;
          gap   <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              if (ev) begin
                state <= S_ARMED;
                gap   <= G_ONE;
              end
            end
            S_ARMED: begin
              if (ev) begin
                last_gap_q <= gap;
                gap        <= G_ONE;
              end else begin
                if (late_det[i]) state <= S_LATE;
                if (gap != G_MAX) gap <= gap + G_ONE;
              end
            end
            S_LATE: begin
              // Late already reported for this interval: measure, no early check.
              if (ev) begin
                last_gap_q <= gap;
                state      <= S_ARMED;
                gap        <= G_ONE;
              end else if (gap != G_MAX) begin
                gap <= gap + G_ONE;
              end
            end
            default: begin
              state <= S_IDLE;
              gap   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  // A new set wins over a same-cycle clear on the same bit.
  assign status_next = (status_q & ~bus.clr_status) | early_det | late_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      early_q  <= '0;
      late_q   <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      early_q  <= early_det;
      late_q   <= late_det;
      status_q <= status_next;
      irq_q    <= |(status_q & bus.irq_en);
    end
  end

  assign bus.early_pulse = early_q;
  assign bus.late_pulse  = late_q;
  assign bus.viol_status = status_q;
  assign bus.last_gap    = last_gap_w;
  assign bus.irq         = irq_q;

`ifdef IVM_VIOL_TS_EN
  logic [TS_W-1:0]   ts_q;
  logic [TS_W-1:0]   fts_q;
  logic [NUM_CH-1:0] fch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q  <= '0;
      fts_q <= '0;
      fch_q <= '0;
    end else begin
      if (bus.en) ts_q <= ts_q + TS_W'(1);
      // Capture only on the all-clear to non-zero transition; hold until
      // the status register is fully cleared again.
      if ((status_q == '0) && (status_next != '0)) begin
        fts_q <= ts_q;
        fch_q <= early_det | late_det;
      end else if (status_next == '0) begin
        fts_q <= '0;
        fch_q <= '0;
      end
    end
  end

  assign bus.first_viol_ts = fts_q;
  assign bus.first_viol_ch = fch_q;
`else
  assign bus.first_viol_ts = {TS_W{1'b0}};
  assign bus.first_viol_ch = {NUM_CH{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_interval_violation_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interval_violation_monitor
//  Purpose  : Self-checking bench for interval_violation_monitor. A reference
//             model based on event timestamps predicts every output each
//             cycle; directed checks pin key values by hand.
//  Revision : 1.0  initial release
// ============================================================================
module tb_interval_violation_monitor;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int TS_W   = 16;

  logic clk;
  logic rst;

  interval_violation_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TS_W(TS_W)) bus ();

  interval_violation_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              now = 0;
  int              last_ev [NUM_CH];
  bit              armed   [NUM_CH];
  bit              late_done [NUM_CH];
  logic [7:0]      m_lg    [NUM_CH];
  logic [3:0]      m_early, m_late, m_status, m_fch;
  logic            m_irq;
  logic [15:0]     m_ts, m_fts;

  initial begin
    forever begin
      @(posedge clk);
      now++;
      if (rst) begin
        for (int i = 0; i < NUM_CH; i++) begin
          armed[i] = 0; late_done[i] = 0; last_ev[i] = 0; m_lg[i] = 8'd0;
        end
        m_early = '0; m_late = '0; m_status = '0; m_irq = 1'b0;
        m_ts = '0; m_fts = '0; m_fch = '0;
      end else begin
        logic [3:0] de, dl, ns;
        de = '0; dl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          int g;
          g = now - last_ev[i];
          if (g > 255) g = 255;
          if (!bus.en) begin
            armed[i] = 0;
          end else if (!armed[i]) begin
            if (bus.event_in[i]) begin
              armed[i] = 1; late_done[i] = 0; last_ev[i] = now;
            end
          end else if (bus.event_in[i]) begin
            m_lg[i] = 8'(g);
            if (!late_done[i] && g < int'(bus.min_gap)) de[i] = 1'b1;
            late_done[i] = 0;
            last_ev[i] = now;
          end else if (!late_done[i] && bus.max_gap != 0 && g == int'(bus.max_gap)) begin
            dl[i] = 1'b1;
            late_done[i] = 1;
          end
        end
        ns = (m_status & ~bus.clr_status) | de | dl;
        m_irq = |(m_status & bus.irq_en);
`ifdef IVM_VIOL_TS_EN
        if (m_status == 0 && ns != 0) begin
          m_fts = m_ts; m_fch = de | dl;
        end else if (ns == 0) begin
          m_fts = '0; m_fch = '0;
        end
        if (bus.en) m_ts = m_ts + 16'd1;
`endif
        m_status = ns; m_early = de; m_late = dl;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("early_pulse", 64'(bus.early_pulse), 64'(m_early));
        chk("late_pulse", 64'(bus.late_pulse), 64'(m_late));
        chk("viol_status", 64'(bus.viol_status), 64'(m_status));
        chk("last_gap", 64'(bus.last_gap), 64'({m_lg[3], m_lg[2], m_lg[1], m_lg[0]}));
        chk("irq", 64'(bus.irq), 64'(m_irq));
        chk("first_viol_ts", 64'(bus.first_viol_ts), 64'(m_fts));
        chk("first_viol_ch", 64'(bus.first_viol_ch), 64'(m_fch));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Each call supplies the inputs for exactly one rising edge.
  task automatic cycle(input logic [3:0] ev, input logic [3:0] clr = 4'h0,
                       input logic e = 1'b1, input logic r = 1'b0);
    @(negedge clk);
    #1;
    bus.event_in   = ev;
    bus.clr_status = clr;
    bus.en         = e;
    rst            = r;
  endtask

  task automatic gap_ev(input logic [3:0] mask, input int g);
    repeat (g - 1) cycle(4'h0);
    cycle(mask);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.event_in = '0; bus.clr_status = '0;
    bus.min_gap = 8'd10; bus.max_gap = 8'd12; bus.irq_en = 4'hF;

    repeat (3) cycle(4'h0, 4'h0, 1'b0, 1'b1);
    cycle(4'h0);
    chk_on = 1'b1;
    chk("reset status", 64'(bus.viol_status), 64'd0);
    chk("reset last_gap", 64'(bus.last_gap), 64'd0);
    chk("reset irq", 64'(bus.irq), 64'd0);

    // Regular spacing on ch0
    cycle(4'h1);
    repeat (4) gap_ev(4'h1, 10);
    cycle(4'h0);
    chk("regular last_gap0", 64'(bus.last_gap[7:0]), 64'd10);
    chk("regular status", 64'(bus.viol_status), 64'd0);
    cycle(4'h0, 4'h0, 1'b0);

    // Early on ch1
    cycle(4'h2);
    gap_ev(4'h2, 10);
    gap_ev(4'h2, 7);
    cycle(4'h0);
    chk("early pulse1", 64'(bus.early_pulse), 64'h2);
    chk("early last_gap1", 64'(bus.last_gap[15:8]), 64'd7);
    chk("early status1", 64'(bus.viol_status[1]), 64'd1);
    chk("irq latency", 64'(bus.irq), 64'd0);
    cycle(4'h0);
    chk("early irq", 64'(bus.irq), 64'd1);
    chk("early one-shot", 64'(bus.early_pulse), 64'h0);
    cycle(4'h0, 4'h0, 1'b0);

    // Late on ch2
    cycle(4'h4);
    repeat (12) cycle(4'h0);
    chk("late not yet", 64'(bus.late_pulse), 64'h0);
    cycle(4'h0);
    chk("late pulse2", 64'(bus.late_pulse), 64'h4);
    cycle(4'h0);
    chk("late once", 64'(bus.late_pulse), 64'h0);
    repeat (5) cycle(4'h0);
    cycle(4'h4);
    cycle(4'h0);
    chk("late last_gap2", 64'(bus.last_gap[23:16]), 64'd20);
    chk("late no early", 64'(bus.early_pulse), 64'h0);

    // Clear race on ch1
    cycle(4'h0, 4'hF, 1'b0);
    cycle(4'h2);
    repeat (4) cycle(4'h0);
    cycle(4'h2, 4'h2);
    cycle(4'h0);
    chk("race status1", 64'(bus.viol_status[1]), 64'd1);
    chk("race early1", 64'(bus.early_pulse), 64'h2);
    cycle(4'h0, 4'h2);
    cycle(4'h0);
    chk("lone clear1", 64'(bus.viol_status[1]), 64'd0);
    cycle(4'h0, 4'h0, 1'b0);

    // Disable mid-interval, re-enable, gap 3 re-arms only
    cycle(4'h1);
    cycle(4'h0);
    cycle(4'h0, 4'h0, 1'b0);
    cycle(4'h1);
    cycle(4'h0);
    chk("reenable no early", 64'(bus.early_pulse), 64'h0);
    chk("reenable last_gap0", 64'(bus.last_gap[7:0]), 64'd10);

    // ch3 violation then reset mid-run
    cycle(4'h8);
    gap_ev(4'h8, 4);
    cycle(4'h0);
    chk("early pulse3", 64'(bus.early_pulse), 64'h8);
`ifdef IVM_VIOL_TS_EN
    chk("first_viol_ch3", 64'(bus.first_viol_ch), 64'h8);
`endif
    cycle(4'h0, 4'h0, 1'b1, 1'b1);
    cycle(4'h0);
    chk("rst status", 64'(bus.viol_status), 64'd0);
    chk("rst early", 64'(bus.early_pulse), 64'd0);
    chk("rst last_gap", 64'(bus.last_gap), 64'd0);
    chk("rst irq", 64'(bus.irq), 64'd0);

    // Boundaries: min_gap=0, max_gap=0, back-to-back events, saturation
    bus.min_gap = 8'd0;
    bus.max_gap = 8'd0;
    cycle(4'h1);
    cycle(4'h1);
    cycle(4'h0);
    chk("gap1 last_gap0", 64'(bus.last_gap[7:0]), 64'd1);
    chk("min0 no early", 64'(bus.early_pulse), 64'h0);
    repeat (260) cycle(4'h0);
    chk("max0 no late", 64'(bus.viol_status), 64'h0);
    cycle(4'h1);
    cycle(4'h0);
    chk("saturated gap", 64'(bus.last_gap[7:0]), 64'd255);
    repeat (3) cycle(4'h0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
